// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative HI/LO divider.
package div_unit_pkg;

    // Number of restoring steps for a full-width operand.
    localparam int unsigned DIV_ITER_COUNT = 32;

    typedef enum logic [1:0] {
        DIV_STATE_IDLE = 2'd0,
        DIV_STATE_BUSY = 2'd1,
        DIV_STATE_DONE = 2'd2
    } div_state_e;

    // Result signs captured when the operation is accepted.
    typedef struct packed {
        logic quo_neg;
        logic rem_neg;
    } div_sign_t;

endpackage

// File: rtl/div_unit_if.sv
// Issue/result bundle between the EX stage and the divider (HI/LO write port).
interface div_unit_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  start;
    logic                  signed_div;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic                  cancel;
    logic                  busy;
    logic                  write_hilo_enable;
    logic [DATA_WIDTH-1:0] write_hi_data;
    logic [DATA_WIDTH-1:0] write_lo_data;

    // Issuer side: the pipeline.
    modport master (
        output start, signed_div, dividend, divisor, cancel,
        input  busy, write_hilo_enable, write_hi_data, write_lo_data
    );

    // Divider side.
    modport slave (
        input  start, signed_div, dividend, divisor, cancel,
        output busy, write_hilo_enable, write_hi_data, write_lo_data
    );
endinterface

// File: rtl/div_unit_step.sv
// One radix-2 restoring iteration on unsigned magnitudes.
module div_step #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem_i,
    input  logic [DATA_WIDTH-1:0] quo_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] rem_o,
    output logic [DATA_WIDTH-1:0] quo_o
);
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH-1:0] diff;
    logic                  fits;

    // Shift {rem,quo} left, trial-subtract, keep the difference if it did not go negative.
    // The difference is formed in DATA_WIDTH bits: whenever it is kept it is below the divisor.
    always_comb begin
        shifted = {rem_i, quo_i[DATA_WIDTH-1]};
        fits    = (shifted >= {1'b0, divisor_i});
        diff    = shifted[DATA_WIDTH-1:0] - divisor_i;
        quo_o   = {quo_i[DATA_WIDTH-2:0], fits};
        rem_o   = fits ? diff : shifted[DATA_WIDTH-1:0];
    end
endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU; writes HI=remainder, LO=quotient.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DIV_ITER_COUNT
) (
    input  logic       clock,
    input  logic       reset,
    div_unit_if.slave  bus
);
    localparam int unsigned           CNT_W     = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]      LAST_ITER = CNT_W'(DATA_WIDTH - 1);

    div_state_e             state_q, state_d;
    logic [CNT_W-1:0]       counter_q;
    logic [DATA_WIDTH-1:0]  rem_q, quo_q, divisor_q;
    div_sign_t              sign_q;
    logic                   enable_q, enable_d;
    logic [DATA_WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;

    logic [DATA_WIDTH-1:0]  step_rem, step_quo;
    logic                   dividend_neg, divisor_neg;
    logic [DATA_WIDTH-1:0]  dividend_abs, divisor_abs;
    logic [DATA_WIDTH-1:0]  rem_fix, quo_fix;

    div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // Operand magnitudes; only signed operations with the MSB set are negated.
    always_comb begin
        dividend_neg = bus.signed_div & bus.dividend[DATA_WIDTH-1];
        divisor_neg  = bus.signed_div & bus.divisor[DATA_WIDTH-1];
        dividend_abs = dividend_neg ? -bus.dividend : bus.dividend;
        divisor_abs  = divisor_neg  ? -bus.divisor  : bus.divisor;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= DIV_STATE_IDLE;
        else       state_q <= state_d;
    end

    // Next state; DONE lasts two cycles: one to register results, one with the strobe high.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DIV_STATE_IDLE:
                if (bus.start)
                    state_d = (bus.divisor == '0) ? DIV_STATE_DONE : DIV_STATE_BUSY;
            DIV_STATE_BUSY:
                if (counter_q == LAST_ITER) state_d = DIV_STATE_DONE;
            DIV_STATE_DONE:
                if (enable_q) state_d = DIV_STATE_IDLE;
            default:
                state_d = DIV_STATE_IDLE;
        endcase
        if (bus.cancel) state_d = DIV_STATE_IDLE;
    end

    // Outputs: busy, write strobe and sign-corrected results to be registered.
    always_comb begin
        rem_fix  = sign_q.rem_neg ? -rem_q : rem_q;
        quo_fix  = sign_q.quo_neg ? -quo_q : quo_q;
        bus.busy = (state_q != DIV_STATE_IDLE);
        enable_d = (state_q == DIV_STATE_DONE) && !enable_q && !bus.cancel;
        hi_d     = enable_d ? rem_fix : hi_q;
        lo_d     = enable_d ? quo_fix : lo_q;
        bus.write_hilo_enable = enable_q;
        bus.write_hi_data     = hi_q;
        bus.write_lo_data     = lo_q;
    end

    // Datapath: operand capture, iteration and step counter.
    // A zero divisor preloads the final HI/LO values with no sign correction.
    always_ff @(posedge clock) begin
        if (reset) begin
            counter_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            sign_q    <= '0;
        end else if (bus.cancel) begin
            counter_q <= '0;
        end else begin
            unique case (state_q)
                DIV_STATE_IDLE: begin
                    if (bus.start) begin
                        counter_q <= '0;
                        divisor_q <= divisor_abs;
                        if (bus.divisor == '0) begin
                            rem_q  <= bus.dividend;
                            quo_q  <= '1;
                            sign_q <= '0;
                        end else begin
                            rem_q          <= '0;
                            quo_q          <= dividend_abs;
                            sign_q.quo_neg <= dividend_neg ^ divisor_neg;
                            sign_q.rem_neg <= dividend_neg;
                        end
                    end
                end
                DIV_STATE_BUSY: begin
                    rem_q     <= step_rem;
                    quo_q     <= step_quo;
                    counter_q <= (counter_q == LAST_ITER) ? '0 : counter_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // HI/LO write port registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            enable_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            enable_q <= enable_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random DIV/DIVU.
module tb_div_unit;
    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    div_unit_if #(.DATA_WIDTH(32)) bus ();

    div_unit #(.DATA_WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: MIPS DIV/DIVU semantics via plain arithmetic.
    function automatic void ref_div(input bit sd, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else if (!sd) begin
            lo = a / b;
            hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lo = 32'h8000_0000;
            hi = 32'd0;
        end else begin
            lo = sa / sb;
            hi = sa % sb;
        end
    endfunction

    // Issues one operation at E0, then watches 40 further edges.
    // cancel_at/restart_at/reset_at name the edge Ek at which that input is sampled (0 = never).
    task automatic run_op(input string name, input bit sd, input logic [31:0] a, input logic [31:0] b,
                          input int cancel_at, input int restart_at, input int reset_at);
        logic [31:0] ehi, elo, ghi, glo;
        int  pulses, first, exp_first;
        bit  exp_pulse;
        pulses = 0;
        first  = -1;
        ghi    = '0;
        glo    = '0;
        ref_div(sd, a, b, ehi, elo);
        exp_first = (b == 32'd0) ? 1 : 33;
        exp_pulse = !((cancel_at > 0 && cancel_at <= exp_first) ||
                      (reset_at  > 0 && reset_at  <= exp_first));

        @(negedge clock);
        bus.start      = 1'b1;
        bus.signed_div = sd;
        bus.dividend   = a;
        bus.divisor    = b;
        @(negedge clock);
        bus.start      = 1'b0;
        bus.signed_div = $urandom_range(0, 1);
        bus.dividend   = $urandom;
        bus.divisor    = $urandom;
        check({name, "/busy_e0"}, 64'(bus.busy), 64'd1);

        for (int k = 1; k <= 40; k++) begin
            bus.cancel = (k == cancel_at);
            bus.start  = (k == restart_at);
            reset      = (k == reset_at);
            @(negedge clock);
            if (bus.write_hilo_enable) begin
                pulses++;
                if (first < 0) begin
                    first = k;
                    ghi   = bus.write_hi_data;
                    glo   = bus.write_lo_data;
                end
            end
            if (exp_pulse && k == exp_first)
                check({name, "/busy_at_pulse"}, 64'(bus.busy), 64'd1);
            if (exp_pulse && k == exp_first + 1)
                check({name, "/busy_after"}, 64'(bus.busy), 64'd0);
            if (k == cancel_at || k == reset_at)
                check({name, "/busy_abort"}, 64'(bus.busy), 64'd0);
            if (k == reset_at)
                check({name, "/reset_outs"},
                      {bus.write_hi_data, bus.write_lo_data} | 64'(bus.write_hilo_enable), 64'd0);
        end
        bus.cancel = 1'b0;
        bus.start  = 1'b0;
        reset      = 1'b0;

        check({name, "/pulses"}, 64'(pulses), exp_pulse ? 64'd1 : 64'd0);
        check({name, "/idle_end"}, 64'(bus.busy), 64'd0);
        if (exp_pulse) begin
            check({name, "/latency"}, 64'(first), 64'(exp_first));
            check({name, "/hi"}, 64'(ghi), 64'(ehi));
            check({name, "/lo"}, 64'(glo), 64'(elo));
            check({name, "/hold"}, {bus.write_hi_data, bus.write_lo_data}, {ehi, elo});
        end
    endtask

    initial begin
        int pulses;
        logic [31:0] ra, rb;
        bit rs;

        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.cancel     = 1'b0;
        bus.signed_div = 1'b0;
        bus.dividend   = '0;
        bus.divisor    = '0;
        repeat (2) @(negedge clock);
        check("reset/busy", 64'(bus.busy), 64'd0);
        check("reset/en", 64'(bus.write_hilo_enable), 64'd0);
        check("reset/hi", 64'(bus.write_hi_data), 64'd0);
        check("reset/lo", 64'(bus.write_lo_data), 64'd0);
        reset = 1'b0;

        run_op("divu_100_7",   1'b0, 32'd100,         32'd7,           0, 0, 0);
        run_op("div_m7_2",     1'b1, 32'hFFFF_FFF9,   32'd2,           0, 0, 0);
        run_op("div_7_m2",     1'b1, 32'd7,           32'hFFFF_FFFE,   0, 0, 0);
        run_op("div_ovf",      1'b1, 32'h8000_0000,   32'hFFFF_FFFF,   0, 0, 0);
        run_op("divu_ovf_ops", 1'b0, 32'h8000_0000,   32'hFFFF_FFFF,   0, 0, 0);
        run_op("divu_5_0",     1'b0, 32'd5,           32'd0,           0, 0, 0);
        run_op("div_m5_0",     1'b1, 32'hFFFF_FFFB,   32'd0,           0, 0, 0);
        run_op("cancel_e11",   1'b0, 32'd100,         32'd7,          11, 0, 0);
        run_op("divu_9_3",     1'b0, 32'd9,           32'd3,           0, 0, 0);
        run_op("cancel_e33",   1'b1, 32'hFFFF_FF00,   32'd13,         33, 0, 0);
        run_op("cancel_e34",   1'b1, 32'd12345,       32'hFFFF_FFF6,  34, 0, 0);
        run_op("cancel_div0",  1'b0, 32'd77,          32'd0,           1, 0, 0);
        run_op("restart_e5",   1'b1, 32'd1000,        32'hFFFF_FFF3,   0, 5, 0);
        run_op("reset_e21",    1'b0, 32'hDEAD_BEEF,   32'd17,          0, 0, 21);

        // Cancel and start in the same idle cycle: nothing may start.
        @(negedge clock);
        bus.start    = 1'b1;
        bus.cancel   = 1'b1;
        bus.dividend = 32'd50;
        bus.divisor  = 32'd5;
        @(negedge clock);
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        check("cancel_start/busy", 64'(bus.busy), 64'd0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (bus.write_hilo_enable) pulses++;
        end
        check("cancel_start/pulses", 64'(pulses), 64'd0);

        for (int n = 0; n < 30; n++) begin
            rs = $urandom_range(0, 1);
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = -$urandom_range(1, 8);
                3:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d", n), rs, ra, rb, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
